// File: rtl/song_pkg.sv
// Shared types, field widths and the note-duration helper for the song player.
package song_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_e;

  localparam int OCT_W   = 3;
  localparam int NOTE_W  = 3;
  localparam int LEN_W   = 4;
  localparam int FULL_W  = 3;
  localparam int UNITS_W = 9;
  localparam logic [NOTE_W-1:0] NOTE_REST = 3'd7;

  // Sixteenth-note units: ((length+1)*16) >> min(full,4), never below one unit.
  function automatic logic [UNITS_W-1:0] dur_units(input logic [LEN_W-1:0]  len,
                                                    input logic [FULL_W-1:0] full);
    logic [UNITS_W-1:0] base;
    logic [FULL_W-1:0]  sh;
    logic [UNITS_W-1:0] u;
    base = {({1'b0, len} + 5'd1), 4'b0000};
    sh   = (full > 3'd4) ? 3'd4 : full;
    u    = base >> sh;
    if (u == 9'd0) begin
      u = 9'd1;
    end else begin
      u = u;
    end
    return u;
  endfunction

endpackage

// File: rtl/song_player_note_timer.sv
// Loadable down-counter; expire_o pulses on the enabled cycle at which the count sits at 1.
module note_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // A count of 0 can only follow a clear; treat it like 1 so the timer never stalls.
  assign expire_o = en_i && (cnt_q <= W'(1));

  // Clear beats load, load beats counting; the count holds while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q > W'(1))) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/song_player.sv
// Song sequencer: walks the song ROM note by note and presents the sounding tone.
// Define SONG_PLAYER_LOOP_EN to wrap at end of track instead of stopping in DONE.
module song_player
  import song_pkg::*;
#(
  parameter int TICKS_PER_16TH = 100_000,
  parameter int GAP_TICKS      = 1_000,
  parameter int IDX_W          = 21
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              stop_i,
  input  logic [2:0]        song_sel_i,
  input  logic [IDX_W-1:0]  rom_track_i,
  input  logic [OCT_W-1:0]  rom_octave_i,
  input  logic [NOTE_W-1:0] rom_note_i,
  input  logic [LEN_W-1:0]  rom_length_i,
  input  logic [FULL_W-1:0] rom_full_i,
  output logic [2:0]        rom_song_o,
  output logic [IDX_W-1:0]  rom_cnt_o,
  output logic              tone_valid_o,
  output logic [OCT_W-1:0]  tone_octave_o,
  output logic [NOTE_W-1:0] tone_note_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int TW = 32;

  state_e            state_q, state_d;
  logic [2:0]        song_q, song_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              tv_q, tv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pause_q;

  logic              dur_load, gap_load, tmr_clr;
  logic              dur_expire, gap_expire;
  logic [TW-1:0]     dur_val;
  logic [IDX_W-1:0]  last_idx;

  assign dur_val  = TW'(dur_units(rom_length_i, rom_full_i)) * TW'(TICKS_PER_16TH);
  assign last_idx = rom_track_i - IDX_W'(1);

  // pause is seen through pause_q so muting and timer freezing take effect on the same cycle.
  note_timer #(.W(TW)) u_dur (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (tmr_clr),
    .load_i     (dur_load),
    .load_val_i (dur_val),
    .en_i       ((state_q == PLAY) && !pause_q),
    .expire_o   (dur_expire)
  );

  note_timer #(.W(TW)) u_gap (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (tmr_clr),
    .load_i     (gap_load),
    .load_val_i (TW'(GAP_TICKS)),
    .en_i       ((state_q == GAP) && !pause_q),
    .expire_o   (gap_expire)
  );

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    cnt_d    = cnt_q;
    oct_d    = oct_q;
    note_d   = note_q;
    done_d   = done_q;
    dur_load = 1'b0;
    gap_load = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = FETCH;
          song_d  = song_sel_i;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      FETCH: begin
        if (pause_q) begin
          state_d = FETCH;
        end else if (rom_track_i == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = PLAY;
          oct_d    = rom_octave_i;
          note_d   = rom_note_i;
          dur_load = 1'b1;
        end
      end
      PLAY: begin
        if (dur_expire) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end else begin
          state_d = PLAY;
        end
      end
      GAP: begin
        if (!gap_expire) begin
          state_d = GAP;
        end else if (cnt_q == last_idx) begin
`ifdef SONG_PLAYER_LOOP_EN
          state_d = FETCH;
          cnt_d   = '0;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = FETCH;
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop_i) begin
      state_d  = IDLE;
      song_d   = song_q;
      cnt_d    = '0;
      done_d   = 1'b0;
      dur_load = 1'b0;
      gap_load = 1'b0;
      tmr_clr  = 1'b1;
    end else begin
      tmr_clr  = 1'b0;
    end
    tv_d   = (state_d == PLAY) && (note_d != NOTE_REST) && !pause_i;
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      song_q  <= 3'd0;
      cnt_q   <= '0;
      oct_q   <= '0;
      note_q  <= '0;
      tv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      cnt_q   <= cnt_d;
      oct_q   <= oct_d;
      note_q  <= note_d;
      tv_q    <= tv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pause_q <= pause_i;
    end
  end

  assign rom_song_o    = song_q;
  assign rom_cnt_o     = cnt_q;
  assign tone_valid_o  = tv_q;
  assign tone_octave_o = oct_q;
  assign tone_note_o   = note_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
